lr_shift_pipe: RTL and testbench

Pipelined, multi-mode generic shifter that extends the combinational left shifter to four shift/rotate modes, with one register stage per shift-amount bit and a valid/ready stream handshake on both sides. It sits between stream producers and consumers in datapaths that need shifted or rotated words at full clock rate with backpressure. Throughput is one word per cycle; latency is fixed at `clog2(width)` cycles.

---
 rtl/lr_shift_pipe.sv | 71 +++++++
 tb/tb_lr_shift_pipe.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lr_shift_pipe.sv
// lr_shift_pipe: pipelined LSL/LSR/ASR/ROL shifter with one register stage per shift-amount bit
// and a global-stall valid/ready handshake; latency is clog2(width) cycles.
module lr_shift_pipe #(
   parameter int width = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [width-1:0]         iBits,
   input  logic [$clog2(width)-1:0] shift,
   input  logic [1:0]               mode,
   input  logic                     iValid,
   output logic                     iReady,
   output logic [width-1:0]         oBits,
   output logic                     oValid,
   input  logic                     oReady
);
   localparam int stages = $clog2(width);
   logic              advance;
   logic [width-1:0]  d_q [stages];
   logic [1:0]        m_q [stages];
   logic [stages-1:0] s_q [stages];
   logic              v_q [stages];
   logic [width-1:0]  d_in [stages];
   logic [width-1:0]  d_nx [stages];
   logic [1:0]        m_in [stages];
   logic [stages-1:0] s_in [stages];
   logic              v_in [stages];
   logic [width-1:0]  fill;
   assign advance = !oValid || oReady;
   assign iReady  = advance;
   assign oBits   = d_q[stages-1];
   assign oValid  = v_q[stages-1];
   // Every stage shift is 2^k < width, so no per-stage modulo is needed; an ASR word keeps its
   // original sign in the MSB through every stage, so the MSB is the fill source.
   always_comb begin
      d_in[0] = iBits;
      m_in[0] = mode;
      s_in[0] = shift;
      v_in[0] = iValid;
      fill    = '0;
      for (int k = 1; k < stages; k++) begin
         d_in[k] = d_q[k-1];
         m_in[k] = m_q[k-1];
         s_in[k] = s_q[k-1];
         v_in[k] = v_q[k-1];
      end
      for (int k = 0; k < stages; k++) begin
         fill    = {width{d_in[k][width-1]}} & ~({width{1'b1}} >> (1 << k));
         d_nx[k] = !s_in[k][k]    ? d_in[k] :
                   m_in[k] == 2'd0 ? d_in[k] << (1 << k) :
                   m_in[k] == 2'd1 ? d_in[k] >> (1 << k) :
                   m_in[k] == 2'd2 ? (d_in[k] >> (1 << k)) | fill :
                                     (d_in[k] << (1 << k)) | (d_in[k] >> (width - (1 << k)));
      end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst)
         for (int k = 0; k < stages; k++) begin
            d_q[k] <= '0;
            m_q[k] <= '0;
            s_q[k] <= '0;
            v_q[k] <= 1'b0;
         end
      else if (advance)
         for (int k = 0; k < stages; k++) begin
            d_q[k] <= d_nx[k];
            m_q[k] <= m_in[k];
            s_q[k] <= s_in[k];
            v_q[k] <= v_in[k];
         end
endmodule

// File: tb/tb_lr_shift_pipe.sv
// tb_lr_shift_pipe: randomized and directed checks of lr_shift_pipe (width 8 and 6)
// against a per-bit reference model and a FIFO scoreboard.
module tb_lr_shift_pipe;
   logic       clk = 1'b0, rst = 1'b1;
   logic [7:0] bits8, obits8;
   logic [2:0] shift8, shift6;
   logic [1:0] mode8, mode6;
   logic       ivalid8, iready8, ovalid8, oready8;
   logic [5:0] bits6, obits6;
   logic       ivalid6, iready6, ovalid6, oready6;
   int         n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   lr_shift_pipe #(.width(8)) dut8 (
      .clk(clk), .rst(rst), .iBits(bits8), .shift(shift8), .mode(mode8), .iValid(ivalid8),
      .iReady(iready8), .oBits(obits8), .oValid(ovalid8), .oReady(oready8));
   lr_shift_pipe #(.width(6)) dut6 (
      .clk(clk), .rst(rst), .iBits(bits6), .shift(shift6), .mode(mode6), .iValid(ivalid6),
      .iReady(iready6), .oBits(obits6), .oValid(ovalid6), .oReady(oready6));

   function automatic logic [7:0] ref_shift(int w, logic [7:0] d, int sh, logic [1:0] m);
      logic [7:0] r = '0;
      for (int i = 0; i < w; i++)
         if (m == 2'd0)      r[i] = (i >= sh) ? d[i-sh] : 1'b0;
         else if (m == 2'd1) r[i] = (i + sh < w) ? d[i+sh] : 1'b0;
         else if (m == 2'd2) r[i] = (i + sh < w) ? d[i+sh] : d[w-1];
         else                r[i] = d[((i - sh) % w + w) % w];
      return r;
   endfunction

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++; if (ovalid8 !== 1'b0) begin n_bad++; $display("FAIL reset_ovalid: got %b want 0", ovalid8); end
      n_cmp++; if (obits8 !== 8'h00) begin n_bad++; $display("FAIL reset_obits: got %h want 00", obits8); end
      n_cmp++; if (iready8 !== 1'b1) begin n_bad++; $display("FAIL reset_iready: got %b want 1", iready8); end
      n_cmp++; if (ovalid6 !== 1'b0) begin n_bad++; $display("FAIL reset_ovalid6: got %b want 0", ovalid6); end
      @(negedge clk);
      rst = 1'b0;
      oready8 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bits8 = 8'($urandom); shift8 = 3'($urandom); mode8 = 2'($urandom); ivalid8 = 1'b1;
         @(negedge clk);
      end
      ivalid8 = 1'b0;
      n_cmp++; if (ovalid8 !== 1'b1) begin n_bad++; $display("FAIL fill_ovalid: got %b want 1", ovalid8); end
      rst = 1'b1;
      #1;
      n_cmp++; if (ovalid8 !== 1'b0) begin n_bad++; $display("FAIL midrst_ovalid: got %b want 0", ovalid8); end
      @(negedge clk);
      rst = 1'b0;
      oready8 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_cmp++; if (ovalid8 !== 1'b0) begin n_bad++; $display("FAIL flushed_ovalid: got %b want 0 at cycle %0d", ovalid8, i); end
      end
   endtask

   task automatic one_word(input bit w6, input logic [7:0] d, input logic [2:0] sh,
                           input logic [1:0] m, input logic [7:0] exp, input string nm);
      int lat = 0;
      logic ov;
      logic [7:0] ob;
      @(negedge clk);
      oready8 = 1'b1; oready6 = 1'b1;
      if (w6) begin bits6 = d[5:0]; shift6 = sh; mode6 = m; ivalid6 = 1'b1; end
      else begin bits8 = d; shift8 = sh; mode8 = m; ivalid8 = 1'b1; end
      do begin
         @(negedge clk);
         ivalid6 = 1'b0; ivalid8 = 1'b0;
         lat++;
         ov = w6 ? ovalid6 : ovalid8;
         ob = w6 ? {2'b00, obits6} : obits8;
      end while (!ov && lat < 10);
      n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL %s_latency: got %0d want 3", nm, lat); end
      n_cmp++; if (ob !== exp) begin n_bad++; $display("FAIL %s_bits: got %h want %h", nm, ob, exp); end
   endtask

   task automatic test_modes();
      one_word(1'b0, 8'h81, 3'd1, 2'd0, 8'h02, "lsl");
      one_word(1'b0, 8'h80, 3'd7, 2'd1, 8'h01, "lsr");
      one_word(1'b0, 8'h80, 3'd3, 2'd2, 8'hF0, "asr_neg");
      one_word(1'b0, 8'h70, 3'd3, 2'd2, 8'h0E, "asr_pos");
      one_word(1'b0, 8'h81, 3'd1, 2'd3, 8'h03, "rol");
   endtask

   task automatic test_np2();
      logic [7:0] d;
      logic [2:0] sh;
      logic [1:0] m;
      one_word(1'b1, 8'h3F, 3'd7, 2'd0, 8'h00, "w6_lsl7");
      one_word(1'b1, 8'h20, 3'd6, 2'd2, 8'h3F, "w6_asr6");
      one_word(1'b1, 8'h01, 3'd7, 2'd3, 8'h02, "w6_rol7");
      for (int i = 0; i < 8; i++) begin
         d = 8'($urandom) & 8'h3F; sh = 3'($urandom); m = 2'($urandom);
         one_word(1'b1, d, sh, m, ref_shift(6, d, sh, m), "w6_rand");
      end
   endtask

   task automatic test_stream();
      logic [7:0] q[$];
      logic [7:0] exp;
      int got = 0, sent = 0, first = -1;
      for (int c = 0; c < 80 && got < 16; c++) begin
         @(negedge clk);
         ivalid8 = sent < 16; bits8 = 8'($urandom); shift8 = 3'($urandom); mode8 = 2'($urandom);
         oready8 = 1'b1;
         #1;
         if (ovalid8 && oready8) begin
            if (first < 0) first = c;
            n_cmp++;
            if (q.size() == 0) begin n_bad++; $display("FAIL stream_spurious: got %h want none", obits8); end
            else begin
               exp = q.pop_front();
               if (obits8 !== exp) begin n_bad++; $display("FAIL stream_bits: got %h want %h", obits8, exp); end
            end
            n_cmp++; if (c != first + got) begin n_bad++; $display("FAIL stream_gap: got cycle %0d want %0d", c, first + got); end
            got++;
         end
         if (ivalid8 && iready8) begin q.push_back(ref_shift(8, bits8, shift8, mode8)); sent++; end
      end
      ivalid8 = 1'b0;
      n_cmp++; if (got != 16) begin n_bad++; $display("FAIL stream_count: got %0d want 16", got); end
   endtask

   task automatic test_backpressure();
      logic [7:0] q[$];
      logic [7:0] exp, held = '0;
      logic hold = 1'b0, acc = 1'b1;
      int got = 0, sent = 0;
      for (int c = 0; c < 60 && got < 5; c++) begin
         @(negedge clk);
         if (acc) begin bits8 = 8'($urandom); shift8 = 3'($urandom); mode8 = 2'($urandom); end
         acc = 1'b0;
         oready8 = c < 3 || c >= 10;
         ivalid8 = sent < 5;
         #1;
         n_cmp++; if (iready8 !== (!ovalid8 || oready8)) begin n_bad++; $display("FAIL bp_iready: got %b want %b", iready8, !ovalid8 || oready8); end
         if (c == 6) begin
            n_cmp++; if (ovalid8 !== 1'b1) begin n_bad++; $display("FAIL bp_stalled: got %b want 1", ovalid8); end
         end
         if (hold) begin
            n_cmp++; if (obits8 !== held) begin n_bad++; $display("FAIL bp_stable: got %h want %h", obits8, held); end
         end
         hold = ovalid8 && !oready8;
         held = obits8;
         if (ovalid8 && oready8) begin
            n_cmp++;
            if (q.size() == 0) begin n_bad++; $display("FAIL bp_spurious: got %h want none", obits8); end
            else begin
               exp = q.pop_front();
               if (obits8 !== exp) begin n_bad++; $display("FAIL bp_bits: got %h want %h", obits8, exp); end
            end
            got++;
         end
         if (ivalid8 && iready8) begin q.push_back(ref_shift(8, bits8, shift8, mode8)); sent++; acc = 1'b1; end
      end
      ivalid8 = 1'b0; oready8 = 1'b1;
      n_cmp++; if (got != 5) begin n_bad++; $display("FAIL bp_count: got %0d want 5", got); end
   endtask

   task automatic test_bubbles();
      logic [7:0] q[$];
      logic [7:0] exp;
      logic bub = 1'b0, acc = 1'b1;
      int got = 0, sent = 0;
      for (int c = 0; c < 300 && got < 12; c++) begin
         @(negedge clk);
         if (acc) begin bits8 = 8'($urandom); shift8 = 3'($urandom); mode8 = 2'($urandom); end
         acc = 1'b0;
         ivalid8 = !bub && sent < 12;
         oready8 = 1'($urandom_range(0, 1));
         #1;
         if (ovalid8 && oready8) begin
            n_cmp++;
            if (q.size() == 0) begin n_bad++; $display("FAIL bub_spurious: got %h want none", obits8); end
            else begin
               exp = q.pop_front();
               if (obits8 !== exp) begin n_bad++; $display("FAIL bub_bits: got %h want %h", obits8, exp); end
            end
            got++;
         end
         if (ivalid8 && iready8) begin q.push_back(ref_shift(8, bits8, shift8, mode8)); sent++; acc = 1'b1; bub = 1'b1; end
         else if (bub) bub = 1'b0;
      end
      ivalid8 = 1'b0; oready8 = 1'b1;
      n_cmp++; if (got != 12) begin n_bad++; $display("FAIL bub_count: got %0d want 12", got); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++; if (ovalid8 !== 1'b0) begin n_bad++; $display("FAIL bub_extra: got %b want 0", ovalid8); end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish within bound");
      $fatal(1, "timeout");
   end

   initial begin
      bits8 = '0; shift8 = '0; mode8 = '0; ivalid8 = 1'b0; oready8 = 1'b1;
      bits6 = '0; shift6 = '0; mode6 = '0; ivalid6 = 1'b0; oready6 = 1'b1;
      repeat (2) @(negedge clk);
      test_reset();
      test_modes();
      test_stream();
      test_backpressure();
      test_np2();
      test_bubbles();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
